seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream stage of the alarm clock core.
- Consumes the six BCD time digits and the Alarm flag, and drives a 6-digit common-anode multiplexed seven-segment display with active-low segment and anode lines.
- Captures a tear-free snapshot of the digits once per scan frame, inserts anti-ghosting blanking between digits, and blinks the whole display while the alarm is ringing.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range is 2 and up.
- BLANK_CYC, 8: cycles at the start of each slot with all anodes off; must be less than SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period.
- LZB, 1: 1 blanks the hour-tens digit when it is 0.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- H_in1, input, 2: hour tens digit, 0-2.
- H_in0, input, 4: hour units digit, 0-9.
- M_in1, input, 4: minute tens digit, 0-5.
- M_in0, input, 4: minute units digit, 0-9.
- S_in1, input, 4: second tens digit, 0-5.
- S_in0, input, 4: second units digit, 0-9.
- alarm_in, input, 1: Alarm flag from the clock core; level-sensitive.
- seg_n, output, 7: segments {g,f,e,d,c,b,a}, active low.
- dp_n, output, 1: decimal point, active low.
- an_n, output, 6: digit anodes, active low. Bit 5 is H tens; bit 0 is S units.

Behaviour:
- Reset (reset_n=0, asynchronous): an_n=6'h3F, seg_n=7'h7F, dp_n=1.
  - Slot counter, digit index, frame counter, blink phase and snapshot registers all clear to 0.
  - All outputs are registered and held until the first slot after reset_n rises.
- Slot counter: counts 0..SCAN_DIV-1.
  - A tick occurs when the counter equals SCAN_DIV-1.
  - On a tick, the digit index advances 0,1,...,5,0. Index 0 drives S units (an_n bit 0); index 5 drives H tens (an_n bit 5).
- Snapshot: on the tick where the index wraps 5->0, all six input digits are registered.
  - Displayed values only change at frame boundaries.
  - Input-to-display latency is at most 6*SCAN_DIV+1 cycles.
- Blanking: while the slot counter is below BLANK_CYC, an_n=6'h3F.
  - Otherwise, the bit for the current index is 0 and all other bits are 1.
  - seg_n is updated at the slot start, so segments are stable before the anode enables.
- Decode, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Values 10-15 show a dash, 7'h3F (segment g only).
- Leading-zero blank: when LZB=1, the snapshot H tens is 0 and the index is 5, seg_n=7'h7F. The anode is still enabled.
- Blink:
  - The frame counter increments on each 5->0 wrap.
  - At BLINK_FRAMES-1 it clears and the blink phase toggles.
  - While alarm_in=1 and blink phase=1, seg_n=7'h7F for all digits.
  - When alarm_in=0, the blink phase is forced to 0 and the frame counter is held at 0, so the next alarm always starts with the display visible.
- alarm_in is not snapshotted. It takes effect at the next slot start.
- dp_n is held at 1 unless the optional feature is compiled in.
- A reset_n assertion mid-slot or mid-frame immediately blanks the outputs. The scan restarts at index 0 with a zeroed snapshot, which displays "00:00:00" with H tens blanked when LZB=1.

Optional Feature:
- Macro: SEG7_COLON_DP_EN.
- Defined: dp_n=0 on indexes 2 and 4 (M units, H units) to form the HH.MM.SS separators.
  - Separators are on while blink phase=0 and off while blink phase=1.
  - Here the blink phase toggles independently of alarm_in, giving a seconds-style flash.
  - When alarm_in=1, the alarm blanking also suppresses the separators.
- Undefined: dp_n is held at 1. The blink phase runs only while alarm_in=1, exactly as in Behaviour.

Decomposition:
- Package seg7_pkg holds:
  - the segment code constants for 0-9, dash and blank;
  - the digit index constants IDX_S0..IDX_H1 (3-bit);
  - the NUM_DIGITS=6 constant.
- Sub-module seg7_decode: a combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed snapshot digit.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, LZB=1):
- Reset release with inputs 1,2:3,4:5,6: the first frame shows zeros with H tens blank (seg_n=7F at index 5). The next frame shows seg_n at indexes 0..5 = 02,12,19,30,24,79, and an_n walks 3E,3D,3B,37,2F,1F with 3F for 1 cycle per slot.
- Input change mid-frame from 12:34:56 to 12:34:57 at index 2: index 0 keeps showing 6 (02) until the next wrap, then shows 7 (78).
- H tens = 0 with inputs 09:00:00: index 5 gives seg_n=7F with an_n=1F; index 4 gives 10. Repeating with LZB=0 gives 40 at index 5.
- Invalid digit S_in0=4'hC: index 0 gives seg_n=3F.
- Alarm: alarm_in=1 for 8 frames gives 2 frames visible, 2 blank, 2 visible, 2 blank. Dropping alarm_in mid-blank restores the digits at the next slot start.
- Async reset: assert reset_n=0 mid-slot at index 3; in the same cycle an_n=3F, seg_n=7F, dp_n=1. After release, the scan restarts at index 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared constants and types for the seg7 scan driver
// Rev     : 1.0
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] IDX_S0 = 3'd0;
    localparam logic [2:0] IDX_S1 = 3'd1;
    localparam logic [2:0] IDX_M0 = 3'd2;
    localparam logic [2:0] IDX_M1 = 3'd3;
    localparam logic [2:0] IDX_H0 = 3'd4;
    localparam logic [2:0] IDX_H1 = 3'd5;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } time_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_decode
// Brief   : BCD to active-low seven-segment decoder; 10-15 show a dash
// Rev     : 1.0
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : 6-digit multiplexed common-anode display driver with per-frame
//           snapshot, inter-digit blanking, leading-zero blank and alarm blink.
//           Optional macro SEG7_COLON_DP_EN adds flashing HH.MM.SS separators.
// Rev     : 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64,
    parameter int LZB          = 1
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic [3:0]            S_in1,
    input  logic [3:0]            S_in0,
    input  logic                  alarm_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_idx;
    logic [FRM_W-1:0]      r_frm;
    logic                  r_blink;
    logic                  r_first;
    time_t                 r_snap;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an_n;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_load;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [2:0]            w_idx_nxt;
    logic [FRM_W-1:0]      w_frm_nxt;
    logic                  w_blink_nxt;
    logic                  w_blink_run;
    time_t                 w_snap_nxt;
    logic [3:0]            w_digit;
    logic [6:0]            w_dec_seg;
    logic [6:0]            w_seg_nxt;
    logic                  w_dp_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    assign w_tick    = (r_cnt == CNT_MAX);
    assign w_wrap    = w_tick && (r_idx == IDX_H1);
    assign w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
    assign w_idx_nxt = !w_tick ? r_idx : ((r_idx == IDX_H1) ? IDX_S0 : r_idx + 3'd1);
    assign w_snap_nxt = w_wrap ? '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0,
                                   s1: S_in1, s0: S_in0} : r_snap;

    // Segment/dp registers reload at every slot start, plus the very first
    // cycle after reset so the initial slot is not left dark.
    assign w_load = (w_cnt_nxt == '0) || r_first;

`ifdef SEG7_COLON_DP_EN
    assign w_blink_run = 1'b1;
    assign w_dp_nxt    = ~(((w_idx_nxt == IDX_M0) || (w_idx_nxt == IDX_H0)) && !w_blink_nxt);
`else
    assign w_blink_run = alarm_in;
    assign w_dp_nxt    = 1'b1;
`endif

    always_comb begin
        w_frm_nxt   = r_frm;
        w_blink_nxt = r_blink;
        if (!w_blink_run) begin
            w_frm_nxt   = '0;
            w_blink_nxt = 1'b0;
        end else if (w_wrap) begin
            if (r_frm == FRM_MAX) begin
                w_frm_nxt   = '0;
                w_blink_nxt = ~r_blink;
            end else begin
                w_frm_nxt = r_frm + FRM_W'(1);
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (w_idx_nxt)
            IDX_S0:  w_digit = w_snap_nxt.s0;
            IDX_S1:  w_digit = w_snap_nxt.s1;
            IDX_M0:  w_digit = w_snap_nxt.m0;
            IDX_M1:  w_digit = w_snap_nxt.m1;
            IDX_H0:  w_digit = w_snap_nxt.h0;
            IDX_H1:  w_digit = {2'b00, w_snap_nxt.h1};
            default: w_digit = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .i_bcd   (w_digit),
        .o_seg_n (w_dec_seg)
    );

    always_comb begin
        w_seg_nxt = w_dec_seg;
        if ((LZB != 0) && (w_idx_nxt == IDX_H1) && (w_snap_nxt.h1 == 2'd0)) begin
            w_seg_nxt = SEG_BLANK;
        end
        if (alarm_in && w_blink_nxt) begin
            w_seg_nxt = SEG_BLANK;
        end
    end

    assign w_an_nxt = (w_cnt_nxt < BLANK_LIM) ? {NUM_DIGITS{1'b1}}
                                              : ~(NUM_DIGITS'(1) << w_idx_nxt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_idx   <= IDX_S0;
            r_frm   <= '0;
            r_blink <= 1'b0;
            r_first <= 1'b1;
            r_snap  <= '0;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= {NUM_DIGITS{1'b1}};
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frm   <= w_frm_nxt;
            r_blink <= w_blink_nxt;
            r_first <= 1'b0;
            r_snap  <= w_snap_nxt;
            r_an_n  <= w_an_nxt;
            if (w_load) begin
                r_seg_n <= w_seg_nxt;
                r_dp_n  <= w_dp_nxt;
            end
        end
    end

    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign an_n  = r_an_n;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Directed scoreboard bench for seg7_scan_driver (default build)
// Rev     : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
    logic       alarm_in;
    logic [6:0] seg_n, seg_n_b;
    logic       dp_n, dp_n_b;
    logic [5:0] an_n, an_n_b;

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                       .BLINK_FRAMES(BLINK_FRAMES), .LZB(1)) dut (
        .clk(clk), .reset_n(reset_n), .H_in1(H_in1), .H_in0(H_in0),
        .M_in1(M_in1), .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0),
        .alarm_in(alarm_in), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
    );

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                       .BLINK_FRAMES(BLINK_FRAMES), .LZB(0)) dut_nolzb (
        .clk(clk), .reset_n(reset_n), .H_in1(H_in1), .H_in0(H_in0),
        .M_in1(M_in1), .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0),
        .alarm_in(alarm_in), .seg_n(seg_n_b), .dp_n(dp_n_b), .an_n(an_n_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
    endtask

    task automatic push_frame(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
        sb.push_back('{idx: 3'd0, seg: e0});
        sb.push_back('{idx: 3'd1, seg: e1});
        sb.push_back('{idx: 3'd2, seg: e2});
        sb.push_back('{idx: 3'd3, seg: e3});
        sb.push_back('{idx: 3'd4, seg: e4});
        sb.push_back('{idx: 3'd5, seg: e5});
    endtask

    // Called positioned on the first cycle of a slot; returns positioned on the next.
    task automatic do_slot(input bit first);
        exp_t       e;
        logic [5:0] an_on;
        logic [6:0] seg_exp;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >0");
            return;
        end
        e     = sb.pop_front();
        an_on = ~(6'b000001 << e.idx);
        for (int c = 0; c < SCAN_DIV; c++) begin
            seg_exp = (first && c == 0) ? 7'h7F : e.seg;
            chk($sformatf("an idx%0d c%0d", e.idx, c), {2'b00, an_n},
                (c < BLANK_CYC) ? 8'h3F : {2'b00, an_on});
            chk($sformatf("seg idx%0d c%0d", e.idx, c), {1'b0, seg_n}, {1'b0, seg_exp});
            chk($sformatf("dp idx%0d c%0d", e.idx, c), {7'd0, dp_n}, 8'h01);
            cyc();
        end
    endtask

    task automatic run_slots(input int n);
        for (int i = 0; i < n; i++) do_slot(1'b0);
    endtask

    initial begin
        set_in(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        alarm_in = 1'b0;
        repeat (3) cyc();

        chk("reset an",   {2'b00, an_n},   8'h3F);
        chk("reset seg",  {1'b0, seg_n},   8'h7F);
        chk("reset dp",   {7'd0, dp_n},    8'h01);
        chk("reset an_b", {2'b00, an_n_b}, 8'h3F);

        // First frame after reset: zeroed snapshot, H tens blanked
        reset_n = 1'b1;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F);
        do_slot(1'b1);
        run_slots(4);
        chk("nolzb first idx5 seg", {1'b0, seg_n_b}, 8'h40);
        run_slots(1);

        // 12:34:56 captured at the wrap
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        run_slots(6);

        // Mid-frame input change is deferred to the next frame
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        run_slots(2);
        S_in0 = 4'd7;
        run_slots(4);
        push_frame(7'h78, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        run_slots(1);
        set_in(2'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
        run_slots(5);

        // 09:00:00 with leading-zero blank
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h7F);
        run_slots(1);
        S_in0 = 4'hC;
        run_slots(4);
        chk("nolzb idx5 seg", {1'b0, seg_n_b}, 8'h40);
        run_slots(1);

        // Invalid digit shows a dash
        push_frame(7'h3F, 7'h40, 7'h40, 7'h40, 7'h10, 7'h7F);
        run_slots(1);
        set_in(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        run_slots(5);

        // Alarm: two frames visible, two blank, repeating
        alarm_in = 1'b1;
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        run_slots(42);

        // Drop alarm mid-blank: digits return at the next slot start
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h24, 7'h79);
        run_slots(2);
        alarm_in = 1'b0;
        run_slots(4);

        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        run_slots(3);
        while (sb.size() > 0) void'(sb.pop_front());

        // Async reset in the middle of slot 3
        cyc();
        chk("pre-reset an idx3", {2'b00, an_n}, 8'h37);
        chk("pre-reset seg idx3", {1'b0, seg_n}, 8'h30);
        reset_n = 1'b0;
        #1;
        chk("async an",  {2'b00, an_n},  8'h3F);
        chk("async seg", {1'b0, seg_n},  8'h7F);
        chk("async dp",  {7'd0, dp_n},   8'h01);
        cyc();
        cyc();
        reset_n = 1'b1;
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F);
        push_frame(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        do_slot(1'b1);
        run_slots(11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
